// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 digest sink slice: digest size,
// byte-index type and the capture FSM state encoding.
package sha256_pkg;

  localparam int unsigned DIGEST_BYTES = 32;
  localparam int unsigned AW           = 5;

  typedef logic [AW-1:0] byte_idx_t;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_e;

endpackage

// File: rtl/digest_byte_buf.sv
// digest_byte_buf: DEPTH x 8 register file with one synchronous write port
// and one read port. HAS_RESET selects an async active-low clear of the
// storage and read register; RD_REG selects registered (1) or direct (0) read.
module digest_byte_buf #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AW        = 5,
  parameter bit          HAS_RESET = 1'b1,
  parameter bit          RD_REG    = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  // Next-state of the storage: single byte write when we is high.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Read sees the pre-write contents, so a same-cycle write/read returns the old byte.
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  if (HAS_RESET) begin : g_rst
    // Storage and read register with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mem_q   <= '{default: '0};
        rdata_q <= '0;
      end else begin
        mem_q   <= mem_d;
        rdata_q <= rdata_d;
      end
    end
  end else begin : g_norst
    logic unused_reset_n;
    assign unused_reset_n = reset_n;

    // Storage and read register without reset.
    always_ff @(posedge clk) begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = RD_REG ? rdata_q : rdata_d;

endmodule

// File: rtl/sha256_digest_sink.sv
// sha256_digest_sink: collects the 32-byte serial digest from the SHA-256
// core into a byte-addressable buffer, flags completion and late bytes.
// Optional expected-digest compare is built when SHA256_DIGEST_CMP_EN is
// defined; otherwise exp_in/exp_we are ignored and match stays 0.
module sha256_digest_sink
  import sha256_pkg::*;
#(
  parameter int unsigned DIGEST_BYTES = sha256_pkg::DIGEST_BYTES,
  parameter int unsigned AW           = sha256_pkg::AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    hash_in,
  input  logic          hash_valid,
  input  logic          clear,
  input  logic [7:0]    exp_in,
  input  logic          exp_we,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   byte_cnt,
  output logic          done,
  output logic          match,
  output logic          overflow
);

  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGEST_BYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGEST_BYTES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          overflow_q, overflow_d;
  logic          mismatch_q, mismatch_d;

  logic          cap_we;
  logic [AW-1:0] cap_idx;
  logic          cmp_diff;

  assign cap_idx = byte_cnt_q[AW-1:0];

  digest_byte_buf #(
    .DEPTH    (DIGEST_BYTES),
    .AW       (AW),
    .HAS_RESET(1'b1),
    .RD_REG   (1'b1)
  ) u_cap_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (cap_we),
    .waddr  (cap_idx),
    .wdata  (hash_in),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

`ifdef SHA256_DIGEST_CMP_EN
  localparam bit CMP_EN = 1'b1;

  logic [AW-1:0] exp_ptr_q, exp_ptr_d;
  logic [7:0]    exp_byte;

  // Expected-byte write pointer: wraps modulo the digest size, restarted by clear.
  always_comb begin
    exp_ptr_d = exp_ptr_q;
    if (clear) begin
      exp_ptr_d = '0;
    end else if (exp_we) begin
      exp_ptr_d = exp_ptr_q + AW'(1);
    end
  end

  // Expected-byte pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_ptr_q <= '0;
    end else begin
      exp_ptr_q <= exp_ptr_d;
    end
  end

  // Direct read so the compare sees the expected byte as stored in the capture cycle.
  digest_byte_buf #(
    .DEPTH    (DIGEST_BYTES),
    .AW       (AW),
    .HAS_RESET(1'b0),
    .RD_REG   (1'b0)
  ) u_exp_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (exp_we),
    .waddr  (exp_ptr_q),
    .wdata  (exp_in),
    .raddr  (cap_idx),
    .rdata  (exp_byte)
  );

  assign cmp_diff = (exp_byte != hash_in);
`else
  localparam bit CMP_EN = 1'b0;

  logic unused_exp;
  assign unused_exp = ^{exp_in, exp_we};
  assign cmp_diff   = 1'b0;
`endif

  // Capture FSM next-state: byte accept, saturating count, sticky flags, clear priority.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = done_q;
    match_d    = match_q;
    overflow_d = overflow_q;
    mismatch_d = mismatch_q;
    cap_we     = 1'b0;
    if (clear) begin
      state_d    = COLLECT;
      byte_cnt_d = '0;
      done_d     = 1'b0;
      match_d    = 1'b0;
      overflow_d = 1'b0;
      mismatch_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (hash_valid) begin
            cap_we     = 1'b1;
            mismatch_d = mismatch_q | cmp_diff;
            if (byte_cnt_q != CNT_FULL) begin
              byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
            if (byte_cnt_q == CNT_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
              match_d = CMP_EN & ~mismatch_d;
            end
          end
        end
        DONE: begin
          if (hash_valid) begin
            overflow_d = 1'b1;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end
  end

  // Capture FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= COLLECT;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      done_q     <= done_d;
      match_q    <= match_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign byte_cnt = byte_cnt_q;
  assign done     = done_q;
  assign match    = match_q;
  assign overflow = overflow_q;

endmodule
